// File: rtl/ee354_gcd_param.sv
// ee354_gcd_param: parametrised GCD core with Start/Ack handshake, one-hot
// state flags and single-step enable (SCEN).
// Optional feature macro: GCD_BINARY_EN. When it is defined, q_Sub uses binary
// (Stein) reduction and common factors of 2 are restored in q_Mult. When it is
// undefined, q_Sub uses pure subtractive Euclid and i_count stays 0.
module ee354_gcd_param #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SCEN,
  input  logic             Start,
  input  logic             Ack,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] AB_GCD,
  output logic [CW-1:0]    i_count,
  output logic             q_I,
  output logic             q_Sub,
  output logic             q_Mult,
  output logic             q_Done
);

  // One-hot encoding so each state flag is a direct register bit
  typedef enum logic [3:0] {
    S_I    = 4'b0001,
    S_SUB  = 4'b0010,
    S_MULT = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] gcd_nxt;
  logic [CW-1:0]    i_nxt;

  // State and datapath registers; Reset overrides SCEN, SCEN=0 holds everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_I;
      A       <= '0;
      B       <= '0;
      AB_GCD  <= '0;
      i_count <= '0;
    end else if (SCEN) begin
      state   <= state_nxt;
      A       <= a_nxt;
      B       <= b_nxt;
      AB_GCD  <= gcd_nxt;
      i_count <= i_nxt;
    end
  end

  // Next-state and next-datapath logic; reduction rules are tried in order
  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    b_nxt     = B;
    gcd_nxt   = AB_GCD;
    i_nxt     = i_count;
    case (state)
      S_I: begin
        if (Start) begin
          a_nxt     = Ain;
          b_nxt     = Bin;
          i_nxt     = '0;
          state_nxt = S_SUB;
        end
      end
      S_SUB: begin
        if (A == B) begin
          gcd_nxt   = A;
          state_nxt = S_MULT;
        end else if (A == '0) begin
          gcd_nxt   = B;
          state_nxt = S_MULT;
        end else if (B == '0) begin
          gcd_nxt   = A;
          state_nxt = S_MULT;
`ifdef GCD_BINARY_EN
        end else if (!A[0] && !B[0]) begin
          a_nxt = A >> 1;
          b_nxt = B >> 1;
          i_nxt = i_count + CW'(1);
        end else if (!A[0]) begin
          a_nxt = A >> 1;
        end else if (!B[0]) begin
          b_nxt = B >> 1;
`endif
        end else if (A > B) begin
          a_nxt = A - B;
        end else begin
          b_nxt = B - A;
        end
      end
      S_MULT: begin
        // Restore the common factors of 2 one shift per enabled edge
        if (i_count == '0) begin
          state_nxt = S_DONE;
        end else begin
          gcd_nxt = {AB_GCD[WIDTH-2:0], 1'b0};
          i_nxt   = i_count - CW'(1);
        end
      end
      S_DONE: begin
        if (Ack) begin
          state_nxt = S_I;
        end
      end
      default: state_nxt = S_I;
    endcase
  end

  // State flags decode straight from the one-hot state register
  assign q_I    = (state == S_I);
  assign q_Sub  = (state == S_SUB);
  assign q_Mult = (state == S_MULT);
  assign q_Done = (state == S_DONE);

endmodule

// File: tb/tb_ee354_gcd_param.sv
// tb_ee354_gcd_param: directed checks of ee354_gcd_param at WIDTH=8 and WIDTH=16.
// Expected cycle counts depend on whether GCD_BINARY_EN is defined.
`timescale 1ns/1ps
module tb_ee354_gcd_param;

`ifdef GCD_BINARY_EN
  localparam int unsigned LAT_36_24 = 10;
  localparam int unsigned LAT_48_18 = 10;
  localparam int unsigned LAT_FFFF  = 12;
  localparam int unsigned FRZ_A     = 18;
  localparam int unsigned FRZ_B     = 12;
  localparam int unsigned FRZ_I     = 1;
`else
  localparam int unsigned LAT_36_24 = 5;
  localparam int unsigned LAT_48_18 = 7;
  localparam int unsigned LAT_FFFF  = 259;
  localparam int unsigned FRZ_A     = 12;
  localparam int unsigned FRZ_B     = 24;
  localparam int unsigned FRZ_I     = 0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        scen  = 1'b1;
  logic        start = 1'b0;
  logic        ack   = 1'b0;
  logic [7:0]  ain   = '0;
  logic [7:0]  bin   = '0;
  logic [7:0]  a8, b8, g8;
  logic [3:0]  i8;
  logic        qi8, qs8, qm8, qd8;

  logic        start16 = 1'b0;
  logic        ack16   = 1'b0;
  logic [15:0] ain16   = '0;
  logic [15:0] bin16   = '0;
  logic [15:0] a16, b16, g16;
  logic [4:0]  i16;
  logic        qi16, qs16, qm16, qd16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ee354_gcd_param #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(reset), .SCEN(scen), .Start(start), .Ack(ack),
    .Ain(ain), .Bin(bin), .A(a8), .B(b8), .AB_GCD(g8), .i_count(i8),
    .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8)
  );

  ee354_gcd_param #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(reset), .SCEN(scen), .Start(start16), .Ack(ack16),
    .Ain(ain16), .Bin(bin16), .A(a16), .B(b16), .AB_GCD(g16), .i_count(i16),
    .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st8();
    return 32'({qi8, qs8, qm8, qd8});
  endfunction

  function automatic logic [31:0] st16();
    return 32'({qi16, qs16, qm16, qd16});
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    ain   = a;
    bin   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Start an 8-bit job and count edges (including the Start edge) to q_Done
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int edges);
    int n;
    start8(a, b);
    n = 1;
    while (!qd8 && n < 600) begin
      tick();
      n++;
    end
    edges = n;
    check("run8_done", 32'(qd8), 32'd1);
  endtask

  task automatic ack8;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_to_idle", st8(), 32'b1000);
  endtask

  initial begin
    int edges;
    int max_i;
    int za[3];
    int zb[3];
    int zg[3];
`ifdef GCD_BINARY_EN
    int ta[5];
    int tb_[5];
    int ti[5];
    ta  = '{18, 9, 9, 6, 3};
    tb_ = '{12, 6, 3, 3, 3};
    ti  = '{1, 2, 2, 2, 2};
`endif
    za = '{0, 20, 0};
    zb = '{20, 0, 0};
    zg = '{20, 20, 0};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_state8", st8(), 32'b1000);
    check("rst_a8", 32'(a8), 32'd0);
    check("rst_b8", 32'(b8), 32'd0);
    check("rst_g8", 32'(g8), 32'd0);
    check("rst_i8", 32'(i8), 32'd0);
    check("rst_state16", st16(), 32'b1000);
    check("rst_g16", 32'(g16), 32'd0);

    // Test 1: (36,24) step by step
    start8(8'd36, 8'd24);
    check("t1_load_state", st8(), 32'b0100);
    check("t1_load_a", 32'(a8), 32'd36);
    check("t1_load_b", 32'(b8), 32'd24);
`ifdef GCD_BINARY_EN
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_trace_a", 32'(a8), 32'(ta[k]));
      check("t1_trace_b", 32'(b8), 32'(tb_[k]));
      check("t1_trace_i", 32'(i8), 32'(ti[k]));
    end
    tick();
    check("t1_mult_state", st8(), 32'b0010);
    check("t1_mult_g3", 32'(g8), 32'd3);
    tick();
    check("t1_mult_g6", 32'(g8), 32'd6);
    check("t1_mult_i1", 32'(i8), 32'd1);
    tick();
    check("t1_mult_g12", 32'(g8), 32'd12);
    check("t1_mult_i0", 32'(i8), 32'd0);
    check("t1_still_mult", st8(), 32'b0010);
    tick();
`else
    tick();
    check("t1_sub_a", 32'(a8), 32'd12);
    tick();
    check("t1_sub_b", 32'(b8), 32'd12);
    tick();
    check("t1_mult_state", st8(), 32'b0010);
    check("t1_mult_g", 32'(g8), 32'd12);
    tick();
`endif
    check("t1_done_state", st8(), 32'b0001);
    check("t1_done_g", 32'(g8), 32'd12);
    // q_Done holds and ignores Start
    ain   = 8'd7;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("t1_hold_state", st8(), 32'b0001);
    check("t1_hold_g", 32'(g8), 32'd12);
    check("t1_hold_a", 32'(a8), 32'(FRZ_A == 18 ? 3 : 12));
    ack8();

    // Test 2: (5,15)
    start8(8'd5, 8'd15);
    tick();
    check("t2_b10", 32'(b8), 32'd10);
    tick();
    check("t2_b5", 32'(b8), 32'd5);
    tick();
    check("t2_mult", st8(), 32'b0010);
    tick();
    check("t2_done_5th", st8(), 32'b0001);
    check("t2_g", 32'(g8), 32'd5);
    check("t2_i", 32'(i8), 32'd0);
    ack8();

    // Test 3: zero operands
    for (int k = 0; k < 3; k++) begin
      run8(8'(za[k]), 8'(zb[k]), edges);
      check("t3_edges", 32'(edges), 32'd3);
      check("t3_g", 32'(g8), 32'(zg[k]));
      check("t3_i", 32'(i8), 32'd0);
      ack8();
    end

    // Test 4: SCEN pattern 1,0,0,1 in q_Sub
    start8(8'd36, 8'd24);
    tick();
    scen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t4_frz_a", 32'(a8), 32'(FRZ_A));
      check("t4_frz_b", 32'(b8), 32'(FRZ_B));
      check("t4_frz_i", 32'(i8), 32'(FRZ_I));
      check("t4_frz_state", st8(), 32'b0100);
    end
    scen  = 1'b1;
    edges = 4;
    while (!qd8 && edges < 600) begin
      tick();
      edges++;
    end
    check("t4_done", 32'(qd8), 32'd1);
    check("t4_edges", 32'(edges), 32'(LAT_36_24 + 2));
    check("t4_g", 32'(g8), 32'd12);
    ack8();

    // Test 5: reset on third q_Sub edge, then (48,18)
    start8(8'd36, 8'd24);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_state", st8(), 32'b1000);
    check("t5_rst_a", 32'(a8), 32'd0);
    check("t5_rst_b", 32'(b8), 32'd0);
    check("t5_rst_g", 32'(g8), 32'd0);
    check("t5_rst_i", 32'(i8), 32'd0);
    run8(8'd48, 8'd18, edges);
    check("t5_edges", 32'(edges), 32'(LAT_48_18));
    check("t5_g", 32'(g8), 32'd6);
    ack8();

    // Test 6: WIDTH=16, (65535,255), Start held two cycles
    ain16   = 16'd65535;
    bin16   = 16'd255;
    start16 = 1'b1;
    tick();
    tick();
    start16 = 1'b0;
    edges   = 2;
    max_i   = 32'(i16);
    while (!qd16 && edges < 2000) begin
      tick();
      edges++;
      if (32'(i16) > max_i) max_i = 32'(i16);
    end
    check("t6_done", 32'(qd16), 32'd1);
    check("t6_edges", 32'(edges), 32'(LAT_FFFF));
    check("t6_g", 32'(g16), 32'd255);
    check("t6_max_i", 32'(max_i), 32'd0);
    ack16 = 1'b1;
    tick();
    ack16 = 1'b0;
    check("t6_idle", st16(), 32'b1000);
    tick();
    tick();
    check("t6_no_restart", st16(), 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
